// File: rtl/fill_sequencer.sv
// Request queue and single-outstanding line-fill sequencer between the Trapper request
// notifications and its availability notifications.
module fill_sequencer #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned CHANNEL_ADDR_WIDTH = 34,
  parameter int unsigned BEATS              = 4,
  parameter int unsigned QUEUE_LENGTH       = 8,
  parameter int unsigned REUSE_LAST         = 1,
  localparam int unsigned OW = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned CW = $clog2(QUEUE_LENGTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] request_notification_addr,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   request_notification_id,
  input  logic [OW-1:0]                 request_notification_offset,
  input  logic                          request_notification_valid,
  output logic                          monitor_bypass_ready,
  output logic [CHANNEL_ADDR_WIDTH-1:0] fill_cmd_addr,
  output logic                          fill_cmd_valid,
  input  logic                          fill_cmd_ready,
  input  logic                          fill_done,
  output logic [CHANNEL_ADDR_WIDTH-1:0] availability_notification_addr,
  output logic [C_S_AXI_ID_WIDTH-1:0]   availability_notification_id,
  output logic [OW-1:0]                 availability_notification_offset,
  output logic                          availability_notification_valid,
  output logic [CW-1:0]                 occupancy,
  output logic                          overflow_error
);

  localparam int unsigned PW = $clog2(QUEUE_LENGTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StNotify} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [CHANNEL_ADDR_WIDTH-1:0] r_q_addr [QUEUE_LENGTH];
  logic [C_S_AXI_ID_WIDTH-1:0]   r_q_id   [QUEUE_LENGTH];
  logic [OW-1:0]                 r_q_off  [QUEUE_LENGTH];

  logic [PW-1:0]                 r_wr_ptr;
  logic [PW-1:0]                 r_rd_ptr;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 w_count_next;

  logic [CHANNEL_ADDR_WIDTH-1:0] r_last_addr;
  logic                          r_last_valid;
  logic                          r_overflow;

  logic                          r_fill_cmd_valid;
  logic [CHANNEL_ADDR_WIDTH-1:0] r_fill_cmd_addr;
  logic                          r_avail_valid;
  logic [CHANNEL_ADDR_WIDTH-1:0] r_avail_addr;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_avail_id;
  logic [OW-1:0]                 r_avail_off;

  logic                          w_empty;
  logic                          w_full;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_reuse_hit;
  logic [CHANNEL_ADDR_WIDTH-1:0] w_head_addr;
  logic [C_S_AXI_ID_WIDTH-1:0]   w_head_id;
  logic [OW-1:0]                 w_head_off;

  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == CW'(QUEUE_LENGTH));
    w_pop       = (r_state == StNotify);
    // A full queue still accepts a push in the cycle the head is popped.
    w_push      = request_notification_valid && (!w_full || w_pop);
    w_head_addr = r_q_addr[r_rd_ptr];
    w_head_id   = r_q_id[r_rd_ptr];
    w_head_off  = r_q_off[r_rd_ptr];
    w_reuse_hit = (REUSE_LAST != 0) && r_last_valid && (w_head_addr == r_last_addr);

    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end

    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_next = w_reuse_hit ? StNotify : StIssue;
        end
      end
      StIssue: begin
        if (fill_cmd_ready) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (fill_done) begin
          w_state_next = StNotify;
        end
      end
      StNotify: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Queue storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= request_notification_addr;
      r_q_id[r_wr_ptr]   <= request_notification_id;
      r_q_off[r_wr_ptr]  <= request_notification_offset;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= StIdle;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_last_addr      <= '0;
      r_last_valid     <= 1'b0;
      r_overflow       <= 1'b0;
      r_fill_cmd_valid <= 1'b0;
      r_fill_cmd_addr  <= '0;
      r_avail_valid    <= 1'b0;
      r_avail_addr     <= '0;
      r_avail_id       <= '0;
      r_avail_off      <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (request_notification_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (r_state == StWait && fill_done) begin
        r_last_addr  <= w_head_addr;
        r_last_valid <= 1'b1;
      end
      // Strobes follow the next state so they are registered yet aligned with it.
      r_fill_cmd_valid <= (w_state_next == StIssue);
      if (r_state == StIdle && w_state_next == StIssue) begin
        r_fill_cmd_addr <= w_head_addr;
      end
      r_avail_valid <= (w_state_next == StNotify);
      if (r_state != StNotify && w_state_next == StNotify) begin
        r_avail_addr <= w_head_addr;
        r_avail_id   <= w_head_id;
        r_avail_off  <= w_head_off;
      end
    end
  end

  always_comb begin
    monitor_bypass_ready             = (r_count < CW'(QUEUE_LENGTH - 1));
    occupancy                        = r_count;
    overflow_error                   = r_overflow;
    fill_cmd_valid                   = r_fill_cmd_valid;
    fill_cmd_addr                    = r_fill_cmd_addr;
    availability_notification_valid  = r_avail_valid;
    availability_notification_addr   = r_avail_addr;
    availability_notification_id     = r_avail_id;
    availability_notification_offset = r_avail_off;
  end

endmodule
